fetch_queue: RTL and testbench

Instruction fetch queue between PC generation and decode. It reads the instruction memory at the PC produced by the PC adder stage and buffers the returned instructions with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake. It back-pressures PC generation through `fetch_stall`, and squashes buffered and in-flight fetches on any jump.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch front end.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [1:0]  JUMP_NONE = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // Address and alignment of the read currently waiting on instruction memory.
  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
  } fetch_tag_t;

  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head is read straight from storage.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);

    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  always_comb begin
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues imem reads at the current PC, buffers the
// returned instructions with their PCs and hands them to decode.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [1:0]  jump,
  output logic        fetch_stall,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  fetch_tag_t    tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic          flush;
  logic          pop;
  logic          issue;
  logic [OW-1:0] occupancy;

  always_comb begin
    flush     = (jump != JUMP_NONE);
    id_valid  = (count != '0);
    pop       = id_valid && id_ready;
    // Slots already claimed once this cycle's pop retires; the in-flight read
    // holds a slot so a full FIFO never sees an unplaceable return.
    occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);
    issue     = !reset && !flush && (occupancy < OW'(DEPTH));

    imem_en     = issue;
    imem_addr   = {pc[31:2], 2'b00};
    fetch_stall = !issue && !flush && !reset;

    inflight_d = issue;
    tag_d      = tag_q;
    if (reset) begin
      tag_d = '0;
    end else if (issue) begin
      tag_d = '{pc: pc, fault: pc_misaligned(pc)};
    end

    push_entry = '{pc:    tag_q.pc,
                   instr: tag_q.fault ? NOP_INSTR : imem_rdata,
                   fault: tag_q.fault};

    id_instr = head.instr;
    id_pc    = head.pc;
    id_fault = head.fault;
  end

  always_ff @(posedge clock) begin
    inflight_q <= inflight_d;
    tag_q      <= tag_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (inflight_q),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based model of the fetch path.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [1:0]  jump;
  logic        fetch_stall;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .jump        (jump),
    .fetch_stall (fetch_stall),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_fault    (id_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl;
  logic [31:0] m_tag_pc;
  bit          m_known;
  bit          m_just_reset;
  logic [31:0] bpc;
  bit          last_issue;
  logic [31:0] last_addr;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input logic [1:0] jmp, input bit rdy, input logic [31:0] target);
    bit          e_pop;
    bit          e_issue;
    logic [31:0] cur_pc;
    ent_t        e;
    @(negedge clock);
    reset      = rst;
    jump       = jmp;
    id_ready   = rdy;
    pc         = bpc;
    imem_rdata = last_issue ? (last_addr ^ 32'hA5A5_0000) : $urandom;
    cur_pc     = bpc;
    #1;
    e_pop   = m_known && (mq.size() != 0) && rdy;
    e_issue = !rst && (jmp == 2'b00) &&
              ((int'(mq.size()) + int'(m_infl) - int'(e_pop)) < int'(DEPTH));

    check_eq("imem_en", imem_en, e_issue);
    check_eq("fetch_stall", fetch_stall, !rst && (jmp == 2'b00) && !e_issue);
    if (e_issue) check_eq("imem_addr", imem_addr, {cur_pc[31:2], 2'b00});
    if (m_known) begin
      check_eq("id_valid", id_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check_eq("id_pc", id_pc, mq[0].pc);
        check_eq("id_instr", id_instr, mq[0].instr);
        check_eq("id_fault", id_fault, mq[0].fault);
      end else if (m_just_reset) begin
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_id_instr", id_instr, 32'h0);
        check_eq("rst_id_fault", id_fault, 1'b0);
      end
    end

    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_infl       = 0;
      m_known      = 1;
      m_just_reset = 1;
      bpc          = 32'h0;
    end else begin
      m_just_reset = 0;
      if (jmp != 2'b00) begin
        mq.delete();
        m_infl = 0;
        bpc    = target;
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (m_infl) begin
          e.pc    = m_tag_pc;
          e.fault = (m_tag_pc[1:0] != 2'b00);
          e.instr = e.fault ? 32'h0 : imem_rdata;
          mq.push_back(e);
        end
        m_infl = e_issue;
        if (e_issue) begin
          m_tag_pc = cur_pc;
          bpc      = cur_pc + 32'd4;
        end
      end
    end
    last_issue = e_issue;
    last_addr  = {cur_pc[31:2], 2'b00};
  endtask

  initial begin
    logic [31:0] tgt;
    n_checks     = 0;
    n_fail       = 0;
    m_infl       = 0;
    m_tag_pc     = '0;
    m_known      = 0;
    m_just_reset = 0;
    bpc          = '0;
    last_issue   = 0;
    last_addr    = '0;
    reset        = 1'b1;
    jump         = 2'b00;
    id_ready     = 1'b0;
    pc           = '0;
    imem_rdata   = '0;

    // Reset then stream.
    repeat (2) step(1, 2'b00, 1, 0);
    repeat (20) step(0, 2'b00, 1, 0);
    // Back-pressure until full, then drain with simultaneous refill.
    repeat (12) step(0, 2'b00, 0, 0);
    repeat (10) step(0, 2'b00, 1, 0);
    // Flush with buffered entries and a read in flight.
    repeat (2) step(0, 2'b00, 0, 0);
    step(0, 2'b01, 0, 32'h0000_0100);
    repeat (8) step(0, 2'b00, 1, 0);
    // Misaligned target.
    step(0, 2'b10, 1, 32'h0000_0006);
    repeat (6) step(0, 2'b00, 1, 0);
    step(0, 2'b11, 1, 32'h0000_0200);
    // Reset with entries buffered.
    repeat (4) step(0, 2'b00, 0, 0);
    step(1, 2'b00, 0, 0);
    repeat (6) step(0, 2'b00, 1, 0);

    // Random mix of ready, jumps and occasional reset.
    for (int i = 0; i < 500; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 59) == 0)
        step(1, 2'b00, $urandom_range(0, 9) < 7, 0);
      else if ($urandom_range(0, 11) == 0)
        step(0, 2'($urandom_range(1, 3)), $urandom_range(0, 9) < 7, tgt);
      else
        step(0, 2'b00, $urandom_range(0, 9) < 7, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
